// File: rtl/csa_resolve_seq.sv
// Carry-save resolver: turns a redundant (ps, sc) pair into one binary sum.
// The full-width carry-propagate add is split into CHUNK-bit slices, one
// slice per cycle, with the slice carry chained through a register. This
// keeps the wide carry chain off the critical path. One operation is in
// flight at a time, with valid/ready handshakes on both sides.
module csa_resolve_seq #(
   parameter int WIDTH = 192,
   parameter int CHUNK = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_ps,
   input  logic [WIDTH-1:0] in_sc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   // The slices must tile the operand exactly.
   if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
      $error("csa_resolve_seq: WIDTH must be a multiple of CHUNK");
   end

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] ps_r;
   logic [WIDTH-1:0] sc_r;
   logic [WIDTH-1:0] sum_r;
   logic [IDXW-1:0]  idx_r;
   logic             carry_r;
   logic             cout_r;
   logic [31:0]      base_s;
   logic [CHUNK:0]   add_s;

   // Next-state logic: accept in IDLE, step through slices in ADD, wait for the handshake in DONE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_s = ADD;
            end else begin
               state_s = IDLE;
            end
         end
         ADD: begin
            if (idx_r == LAST_IDX) begin
               state_s = DONE;
            end else begin
               state_s = ADD;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Slice adder: the current slice of ps plus the current slice of sc plus the chained carry.
   always_comb begin
      base_s = 32'(idx_r) * 32'(CHUNK);
      add_s  = {1'b0, ps_r[base_s +: CHUNK]}
             + {1'b0, sc_r[base_s +: CHUNK]}
             + {{CHUNK{1'b0}}, carry_r};
   end

   // State register, plus handshake flags registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         in_ready_r  <= (state_s == IDLE);
         out_valid_r <= (state_s == DONE);
      end
   end

   // Datapath: capture operands on accept, then write one sum slice and carry per ADD cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps_r    <= {WIDTH{1'b0}};
         sc_r    <= {WIDTH{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         idx_r   <= {IDXW{1'b0}};
         carry_r <= 1'b0;
         cout_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  ps_r    <= in_ps;
                  sc_r    <= in_sc;
                  idx_r   <= {IDXW{1'b0}};
                  carry_r <= 1'b0;
               end
            end
            ADD: begin
               sum_r[base_s +: CHUNK] <= add_s[CHUNK-1:0];
               carry_r                <= add_s[CHUNK];
               if (idx_r == LAST_IDX) begin
                  cout_r <= add_s[CHUNK];
                  idx_r  <= {IDXW{1'b0}};
               end else begin
                  idx_r  <= idx_r + {{(IDXW-1){1'b0}}, 1'b1};
               end
            end
            DONE: begin
               // Result is held until the downstream handshake.
            end
            default: begin
               // Unreachable encoding; the state register recovers to IDLE.
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_sum   = sum_r;
   assign out_cout  = cout_r;

endmodule

// File: tb/tb_csa_resolve_seq.sv
// Testbench for csa_resolve_seq. It instantiates the block three times,
// with CHUNK set to 32, 64 and 192. Every result is checked against a plain
// (WIDTH+1)-bit addition of the operands.
module tb_csa_resolve_seq;

   localparam int W = 192;

   logic         clk = 1'b0;
   logic         rst;
   logic         iv   [3];
   logic         ordy [3];
   logic         irdy [3];
   logic         ov   [3];
   logic         oc   [3];
   logic [W-1:0] ips  [3];
   logic [W-1:0] isc  [3];
   logic [W-1:0] osum [3];

   int     nch [3];
   int     checks = 0;
   int     errors = 0;
   longint last_acc = 0;
   longint prev_acc = 0;

   always #5 clk = ~clk;

   csa_resolve_seq #(.WIDTH(W), .CHUNK(32)) u_c32 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
      .in_ps(ips[0]), .in_sc(isc[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_sum(osum[0]), .out_cout(oc[0]));

   csa_resolve_seq #(.WIDTH(W), .CHUNK(64)) u_c64 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
      .in_ps(ips[1]), .in_sc(isc[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_sum(osum[1]), .out_cout(oc[1]));

   csa_resolve_seq #(.WIDTH(W), .CHUNK(192)) u_c192 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
      .in_ps(ips[2]), .in_sc(isc[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
      .out_sum(osum[2]), .out_cout(oc[2]));

   function automatic logic [W-1:0] rand192();
      logic [W-1:0] v;
      for (int i = 0; i < 6; i++) begin
         v[i*32 +: 32] = $urandom;
      end
      return v;
   endfunction

   // One complete operation on instance k, starting at a falling edge with that instance idle.
   task automatic run_op(input int k, input logic [W-1:0] ps, input logic [W-1:0] sc,
                         input int stall);
      logic [W:0] exp;
      int         cnt;
      exp = {1'b0, ps} + {1'b0, sc};
      ordy[k] = (stall == 0);
      checks++;
      if (irdy[k] !== 1'b1) begin
         errors++;
         $display("FAIL ready_before_accept k=%0d got %b want 1", k, irdy[k]);
      end
      iv[k]  = 1'b1;
      ips[k] = ps;
      isc[k] = sc;
      @(negedge clk);
      prev_acc = last_acc;
      last_acc = longint'($time) - 64'sd5;
      iv[k]  = 1'b0;
      ips[k] = 'x;
      isc[k] = 'x;
      checks++;
      if (irdy[k] !== 1'b0) begin
         errors++;
         $display("FAIL busy_after_accept k=%0d in_ready got %b want 0", k, irdy[k]);
      end
      cnt = 0;
      while (ov[k] !== 1'b1 && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      checks++;
      if (cnt != nch[k]) begin
         errors++;
         $display("FAIL latency k=%0d got %0d want %0d", k, cnt, nch[k]);
      end
      checks++;
      if (osum[k] !== exp[W-1:0] || oc[k] !== exp[W]) begin
         errors++;
         $display("FAIL sum k=%0d got %b_%h want %b_%h", k, oc[k], osum[k], exp[W], exp[W-1:0]);
      end
      for (int s = 0; s < stall; s++) begin
         iv[k]  = 1'($urandom_range(0, 1));
         ips[k] = rand192();
         isc[k] = rand192();
         @(negedge clk);
         checks++;
         if (ov[k] !== 1'b1 || irdy[k] !== 1'b0 || osum[k] !== exp[W-1:0] || oc[k] !== exp[W]) begin
            errors++;
            $display("FAIL stall_hold k=%0d cyc=%0d valid=%b ready=%b got %b_%h want %b_%h",
                     k, s, ov[k], irdy[k], oc[k], osum[k], exp[W], exp[W-1:0]);
         end
      end
      iv[k]   = 1'b0;
      ips[k]  = 'x;
      isc[k]  = 'x;
      ordy[k] = 1'b1;
      @(negedge clk);
      ordy[k] = 1'b0;
      checks++;
      if (ov[k] !== 1'b0 || irdy[k] !== 1'b1 || osum[k] !== exp[W-1:0] || oc[k] !== exp[W]) begin
         errors++;
         $display("FAIL after_handshake k=%0d valid=%b ready=%b got %b_%h want %b_%h",
                  k, ov[k], irdy[k], oc[k], osum[k], exp[W], exp[W-1:0]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (irdy[k] !== 1'b1 || ov[k] !== 1'b0 || osum[k] !== '0 || oc[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state k=%0d ready=%b valid=%b cout=%b sum=%h want 1 0 0 0",
                     k, irdy[k], ov[k], oc[k], osum[k]);
         end
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      run_op(0, 192'd5, 192'd3, 0);
   endtask

   task automatic test_ripple();
      logic [W-1:0] ones;
      ones = '1;
      run_op(0, ones, 192'd1, 0);
   endtask

   task automatic test_chunk_boundary();
      logic [W-1:0] a;
      a = '0;
      a[31] = 1'b1;
      run_op(0, a, a, 0);
      a = '0;
      a[191] = 1'b1;
      run_op(0, a, a, 0);
   endtask

   task automatic test_stall_done();
      run_op(0, rand192(), rand192(), 10);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k += 2) begin
         run_op(k, rand192(), rand192(), 0);
         run_op(k, rand192(), rand192(), 0);
         checks++;
         if (last_acc - prev_acc != longint'((nch[k] + 2) * 10)) begin
            errors++;
            $display("FAIL back_to_back_period k=%0d got %0d want %0d",
                     k, last_acc - prev_acc, (nch[k] + 2) * 10);
         end
      end
   endtask

   task automatic test_reset_mid_add();
      bit seen;
      iv[0]   = 1'b1;
      ips[0]  = rand192();
      isc[0]  = rand192();
      ordy[0] = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (irdy[0] !== 1'b1 || ov[0] !== 1'b0 || osum[0] !== '0 || oc[0] !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_add ready=%b valid=%b cout=%b sum=%h want 1 0 0 0",
                  irdy[0], ov[0], oc[0], osum[0]);
      end
      seen = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (ov[0] === 1'b1) seen = 1'b1;
      end
      rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (ov[0] === 1'b1) seen = 1'b1;
      end
      ordy[0] = 1'b0;
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL abandoned_valid got out_valid pulse want none");
      end
      run_op(0, rand192(), rand192(), 0);
   endtask

   task automatic test_random();
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           st;
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 1000; n++) begin
            a = rand192();
            case ($urandom_range(0, 5))
               0: begin a = '1; b = rand192() & 192'hFF; end
               1: b = ~a;
               2: b = ~a + 192'd1;
               default: b = rand192();
            endcase
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_op(k, a, b, st);
         end
      end
   endtask

   initial begin
      nch[0] = 6;
      nch[1] = 3;
      nch[2] = 1;
      for (int k = 0; k < 3; k++) begin
         iv[k]   = 1'b0;
         ordy[k] = 1'b0;
         ips[k]  = '0;
         isc[k]  = '0;
      end
      test_reset();
      test_basic();
      test_ripple();
      test_chunk_boundary();
      test_stall_done();
      test_back_to_back();
      test_reset_mid_add();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
